ddr_cmd_scheduler: RTL and testbench
====================================

DDR_CMD_SCHEDULER -- requirements
Module: ddr_cmd_scheduler

Interface
REQ-001 SHALL have parameter TRCD, default 4, ACT-to-CAS delay in CK_t cycles (min 2).
REQ-002 SHALL have parameter TRP, default 4, PRE-to-ACT delay in cycles (min 2).
REQ-003 SHALL have parameter TCCD, default 4, CAS occupancy in cycles for BL8 (even, min 2); BL4 uses TCCD/2.
REQ-004 SHALL have parameter TREFI, default 1560, refresh interval in cycles.
REQ-005 SHALL have parameter TRFC, default 88, REF-to-next-command delay in cycles.
REQ-006 SHALL have these ports, clock and reset first:
- CK_t  in  1  sole clock, all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  scheduler can accept a request.
- req_wr  in  1  1 = write, 0 = read.
- req_bg  in  2  bank group.
- req_ba  in  2  bank.
- req_row  in  15  row address.
- req_col  in  10  column address.
- bl8  in  1  1 = BL8, 0 = BL4.
- cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14  out  1 each  DDR4 command pins.
- bg_addr  out  2; ba_addr  out  2; a_addr  out  14 (A13..A0).
- rd_start, wr_start  out  1 each  one-cycle pulse coincident with RD/WR command.
- busy  out  1  high in every state except IDLE.

Function
REQ-007 SHALL drive DES (cs_n=1, act_n, ras_n_a16, cas_n_a15, we_n_a14 = 1; bg_addr, ba_addr, a_addr = 0) in every cycle no command is issued.
REQ-008 SHALL encode {cs_n,act_n,ras,cas,we}: WR 01100, RD 01101, PRE 01010, REF 01001; ACT drives cs_n=0, act_n=0, ras_n_a16=cas_n_a15=0, we_n_a14=row[14], a_addr=row[13:0].
REQ-009 SHALL drive a_addr[9:0]=col, a_addr[12]=bl8, other bits 0 on RD/WR; a_addr[10]=0 on single-bank PRE, 1 on PRE-all.
REQ-010 SHALL keep a 16-entry open-row table (index {bg,ba}: valid bit + 15-bit row).
REQ-011 SHALL implement FSM IDLE, PRE, TRP_WAIT, ACT, TRCD_WAIT, CAS, TCCD_WAIT, REF, TRFC_WAIT; each command state lasts exactly one cycle.
REQ-012 SHALL assert req_ready only in IDLE with no refresh pending; request latched on req_valid && req_ready.
REQ-013 SHALL go from IDLE after accept: table hit -> CAS; bank valid with other row -> PRE; bank closed -> ACT.
REQ-014 SHALL issue PRE one cycle after accept (miss), clear that bank's valid, then issue ACT exactly TRP cycles after PRE.
REQ-015 SHALL on ACT set valid and row for the bank, then issue CAS exactly TRCD cycles after ACT.
REQ-016 SHALL pulse wr_start (req_wr=1) or rd_start (req_wr=0) in the CAS cycle only, then return to IDLE exactly TCCD (BL8) or TCCD/2 (BL4) cycles after CAS.
REQ-017 SHALL leave rows open after CAS (open-page policy).
REQ-018 SHALL never change the latched request while busy; req_* inputs ignored outside accept cycle.

Reset
REQ-019 SHALL on reset=1 at a clock edge, in any state: FSM -> IDLE, DES on pins, rd_start=wr_start=busy=0, req_ready=1, all table valids 0, all counters 0, refresh pending 0.
REQ-020 SHALL drop any in-flight request on reset without emitting further commands.

Configuration
REQ-021 SHALL with AUTO_REF_EN defined include a refresh counter that sets refresh-pending every TREFI cycles (pending saturates, never counts twice).
REQ-022 SHALL with AUTO_REF_EN, in IDLE with pending set: if any valid bit set issue PRE-all, wait TRP, then REF; else REF immediately; wait TRFC; clear all valids and pending; return to IDLE.
REQ-023 SHALL, if refresh becomes pending in an accept cycle, service the request first and refresh at the next IDLE.
REQ-024 SHALL without AUTO_REF_EN omit counter, REF and TRFC_WAIT logic; req_ready = (state==IDLE).

Verification
REQ-025 Reset, read bg=1 ba=2 row=0x0123 col=0x040 BL8 -> ACT at t, RD at t+4 with rd_start, a_addr[9:0]=0x040, a_addr[12]=1, IDLE at t+8.
REQ-026 Repeat same bank/row as write BL4 -> WR one cycle after accept, wr_start pulse, no ACT/PRE, IDLE 2 cycles after WR.
REQ-027 Same bank, row=0x0456 -> PRE (a_addr[10]=0) then ACT 4 cycles later with row 0x0456, CAS 4 cycles after ACT.
REQ-028 AUTO_REF_EN, TREFI=100, one row open, idle -> PRE-all (a_addr[10]=1), REF 4 cycles later, req_ready=0 for TRFC cycles, next access to that bank starts with ACT.
REQ-029 reset=1 during TRCD_WAIT -> next cycle DES, busy=0, req_ready=1; subsequent access to same bank issues ACT (table cleared).

Source files
------------

// File: rtl/ddr_cmd_scheduler.sv
// DDR4 single-request command scheduler with an open-page, per-bank open-row table.
// Optional periodic refresh is built when AUTO_REF_EN is defined.
module ddr_cmd_scheduler #(
  parameter int TRCD  = 4,
  parameter int TRP   = 4,
  parameter int TCCD  = 4,
  parameter int TREFI = 1560,
  parameter int TRFC  = 88
) (
  input  logic        CK_t,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_bg,
  input  logic [1:0]  req_ba,
  input  logic [14:0] req_row,
  input  logic [9:0]  req_col,
  input  logic        bl8,
  output logic        cs_n,
  output logic        act_n,
  output logic        ras_n_a16,
  output logic        cas_n_a15,
  output logic        we_n_a14,
  output logic [1:0]  bg_addr,
  output logic [1:0]  ba_addr,
  output logic [13:0] a_addr,
  output logic        rd_start,
  output logic        wr_start,
  output logic        busy
);

  localparam int D1    = (TRCD > TRP) ? TRCD : TRP;
  localparam int D2    = (D1 > TCCD) ? D1 : TCCD;
  localparam int D3    = (D2 > TRFC) ? D2 : TRFC;
  localparam int D4    = (D3 > TREFI) ? D3 : TREFI;
  localparam int CNT_W = $clog2(D4 + 1);
  localparam int OCC8  = TCCD;
  localparam int OCC4  = TCCD / 2;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_TRP_WAIT, S_ACT, S_TRCD_WAIT,
    S_CAS, S_TCCD_WAIT, S_REF, S_TRFC_WAIT
  } state_t;

  typedef struct packed {
    logic [4:0]  cmd;  // {cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14}
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [13:0] a;
  } pins_t;

  localparam pins_t DES = '{cmd: 5'b11111, bg: 2'b00, ba: 2'b00, a: 14'h0000};

  function automatic pins_t f_act(input logic [14:0] row, input logic [1:0] bg, input logic [1:0] ba);
    pins_t p;
    p.cmd = {4'b0000, row[14]};
    p.bg  = bg;
    p.ba  = ba;
    p.a   = row[13:0];
    return p;
  endfunction

  function automatic pins_t f_cas(input logic wr, input logic [1:0] bg, input logic [1:0] ba,
                                  input logic [9:0] col, input logic b8);
    pins_t p;
    p.cmd = {4'b0110, ~wr};
    p.bg  = bg;
    p.ba  = ba;
    p.a   = {1'b0, b8, 2'b00, col};
    return p;
  endfunction

  function automatic pins_t f_pre(input logic [1:0] bg, input logic [1:0] ba, input logic all);
    pins_t p;
    p.cmd = 5'b01010;
    p.bg  = bg;
    p.ba  = ba;
    p.a   = {3'b000, all, 10'h000};
    return p;
  endfunction

  state_t             r_state;
  pins_t              r_pins;
  logic               r_rd_start;
  logic               r_wr_start;
  logic [CNT_W-1:0]   r_cnt;
  logic [15:0]        r_valid;
  logic [14:0]        r_row_tbl [16];
  logic               r_wr;
  logic [1:0]         r_bg;
  logic [1:0]         r_ba;
  logic [14:0]        r_row;
  logic [9:0]         r_col;
  logic               r_bl8;

  logic [3:0]         w_idx;
  logic [3:0]         r_idx_w;
  logic               w_hit;
  logic               w_ref_pend;

  assign w_idx   = {req_bg, req_ba};
  assign r_idx_w = {r_bg, r_ba};
  assign w_hit   = r_valid[w_idx] && (r_row_tbl[w_idx] == req_row);

`ifdef AUTO_REF_EN
  logic [CNT_W-1:0]   r_ref_cnt;
  logic               r_ref_pend;
  logic               r_in_ref;
  logic               w_ref_tick;

  assign w_ref_tick = (r_ref_cnt == CNT_W'(TREFI - 1));
  assign w_ref_pend = r_ref_pend;

  always_ff @(posedge CK_t) begin
    if (reset) begin
      r_ref_cnt <= '0;
    end else if (w_ref_tick) begin
      r_ref_cnt <= '0;
    end else begin
      r_ref_cnt <= r_ref_cnt + 1'b1;
    end
  end
`else
  assign w_ref_pend = 1'b0;
`endif

  always_ff @(posedge CK_t) begin
    r_pins     <= DES;
    r_rd_start <= 1'b0;
    r_wr_start <= 1'b0;
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_valid <= '0;
      r_wr    <= 1'b0;
      r_bg    <= '0;
      r_ba    <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_bl8   <= 1'b0;
`ifdef AUTO_REF_EN
      r_ref_pend <= 1'b0;
      r_in_ref   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
`ifdef AUTO_REF_EN
          if (r_ref_pend) begin
            r_in_ref <= 1'b1;
            if (|r_valid) begin
              r_state <= S_PRE;
              r_pins  <= f_pre(2'b00, 2'b00, 1'b1);
            end else begin
              r_state  <= S_REF;
              r_pins.cmd <= 5'b01001;
            end
          end else
`endif
          if (req_valid) begin
            r_wr  <= req_wr;
            r_bg  <= req_bg;
            r_ba  <= req_ba;
            r_row <= req_row;
            r_col <= req_col;
            r_bl8 <= bl8;
            if (w_hit) begin
              r_state    <= S_CAS;
              r_pins     <= f_cas(req_wr, req_bg, req_ba, req_col, bl8);
              r_rd_start <= ~req_wr;
              r_wr_start <= req_wr;
            end else if (r_valid[w_idx]) begin
              r_state <= S_PRE;
              r_pins  <= f_pre(req_bg, req_ba, 1'b0);
            end else begin
              r_state <= S_ACT;
              r_pins  <= f_act(req_row, req_bg, req_ba);
            end
          end
        end
        S_PRE: begin
`ifdef AUTO_REF_EN
          if (!r_in_ref) r_valid[r_idx_w] <= 1'b0;
`else
          r_valid[r_idx_w] <= 1'b0;
`endif
          r_cnt   <= CNT_W'(TRP - 2);
          r_state <= S_TRP_WAIT;
        end
        S_TRP_WAIT: begin
          if (r_cnt == '0) begin
`ifdef AUTO_REF_EN
            if (r_in_ref) begin
              r_state    <= S_REF;
              r_pins.cmd <= 5'b01001;
            end else begin
              r_state <= S_ACT;
              r_pins  <= f_act(r_row, r_bg, r_ba);
            end
`else
            r_state <= S_ACT;
            r_pins  <= f_act(r_row, r_bg, r_ba);
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_ACT: begin
          r_valid[r_idx_w]   <= 1'b1;
          r_row_tbl[r_idx_w] <= r_row;
          r_cnt              <= CNT_W'(TRCD - 2);
          r_state            <= S_TRCD_WAIT;
        end
        S_TRCD_WAIT: begin
          if (r_cnt == '0) begin
            r_state    <= S_CAS;
            r_pins     <= f_cas(r_wr, r_bg, r_ba, r_col, r_bl8);
            r_rd_start <= ~r_wr;
            r_wr_start <= r_wr;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_CAS: begin
          // BL4 with TCCD=2 occupies only the CAS cycle itself
          if (!r_bl8 && OCC4 <= 1) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt   <= r_bl8 ? CNT_W'(OCC8 - 2) : CNT_W'(OCC4 - 2);
            r_state <= S_TCCD_WAIT;
          end
        end
        S_TCCD_WAIT: begin
          if (r_cnt == '0) r_state <= S_IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
`ifdef AUTO_REF_EN
        S_REF: begin
          if (TRFC <= 1) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_ref_pend <= 1'b0;
            r_in_ref   <= 1'b0;
          end else begin
            r_cnt   <= CNT_W'(TRFC - 2);
            r_state <= S_TRFC_WAIT;
          end
        end
        S_TRFC_WAIT: begin
          if (r_cnt == '0) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_ref_pend <= 1'b0;
            r_in_ref   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
`ifdef AUTO_REF_EN
      // A fresh interval tick wins over the end-of-refresh clear
      if (w_ref_tick) r_ref_pend <= 1'b1;
`endif
    end
  end

  assign {cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14} = r_pins.cmd;
  assign bg_addr   = r_pins.bg;
  assign ba_addr   = r_pins.ba;
  assign a_addr    = r_pins.a;
  assign rd_start  = r_rd_start;
  assign wr_start  = r_wr_start;
  assign busy      = (r_state != S_IDLE);
  assign req_ready = (r_state == S_IDLE) && !w_ref_pend;

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Directed bench for ddr_cmd_scheduler: open-page read/write, row miss, reset abort,
// and (when AUTO_REF_EN is defined) the refresh sequence.
module tb_ddr_cmd_scheduler;

  logic        CK_t = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [1:0]  req_bg = '0;
  logic [1:0]  req_ba = '0;
  logic [14:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic        bl8 = 1'b0;
  logic        cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14;
  logic [1:0]  bg_addr, ba_addr;
  logic [13:0] a_addr;
  logic        rd_start, wr_start, busy;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [22:0] DES_P = {5'b11111, 18'h0};

  logic [22:0] pins;
  assign pins = {cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14, bg_addr, ba_addr, a_addr};

  ddr_cmd_scheduler #(
    .TRCD(4), .TRP(4), .TCCD(4), .TREFI(100), .TRFC(20)
  ) dut (
    .CK_t(CK_t), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col), .bl8(bl8),
    .cs_n(cs_n), .act_n(act_n), .ras_n_a16(ras_n_a16), .cas_n_a15(cas_n_a15), .we_n_a14(we_n_a14),
    .bg_addr(bg_addr), .ba_addr(ba_addr), .a_addr(a_addr),
    .rd_start(rd_start), .wr_start(wr_start), .busy(busy)
  );

  always #5 CK_t = ~CK_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CK_t);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    check("rst_pins", pins, DES_P);
    check("rst_flags", {busy, req_ready, rd_start, wr_start}, 4'b0100);
    reset = 1'b0;
  endtask

  // After return the bench sits one cycle past the accept edge.
  task automatic send(input logic wr, input logic [1:0] bg, input logic [1:0] ba,
                      input logic [14:0] row, input logic [9:0] col, input logic b8);
    int n = 0;
    while (!req_ready && n < 200) begin
      step();
      n++;
    end
    check("accept_ready", req_ready, 1'b1);
    req_wr = wr; req_bg = bg; req_ba = ba; req_row = row; req_col = col; bl8 = b8;
    req_valid = 1'b1;
    $display("txn %s bg=%0d ba=%0d row=0x%04h col=0x%03h bl8=%0d", wr ? "WR" : "RD", bg, ba, row, col, b8);
    step();
    req_valid = 1'b0;
    req_wr = ~wr; req_bg = ~bg; req_ba = ~ba; req_row = ~row; req_col = ~col; bl8 = ~b8;
  endtask

  task automatic des_cycles(input string tag, input int n, input logic exp_busy);
    for (int i = 0; i < n; i++) begin
      step();
      check(tag, {busy, pins}, {exp_busy, DES_P});
    end
  endtask

  initial begin
    do_reset();
    step();
    check("idle_pins", pins, DES_P);

    // Closed bank: ACT, RD 4 cycles later, idle 4 cycles after RD
    send(1'b0, 2'd1, 2'd2, 15'h0123, 10'h040, 1'b1);
    check("rd1_act", pins, {5'b00000, 2'd1, 2'd2, 14'h0123});
    check("rd1_busy", {busy, req_ready}, 2'b10);
    des_cycles("rd1_trcd", 3, 1'b1);
    step();
    check("rd1_rd", pins, {5'b01101, 2'd1, 2'd2, 14'h1040});
    check("rd1_start", {rd_start, wr_start}, 2'b10);
    des_cycles("rd1_burst", 3, 1'b1);
    step();
    check("rd1_idle", {busy, req_ready}, 2'b01);

    // Row hit, BL4 write: WR next cycle, idle 2 cycles later
    send(1'b1, 2'd1, 2'd2, 15'h0123, 10'h040, 1'b0);
    check("wr_hit_cmd", pins, {5'b01100, 2'd1, 2'd2, 14'h0040});
    check("wr_hit_start", {rd_start, wr_start}, 2'b01);
    des_cycles("wr_hit_burst", 1, 1'b1);
    step();
    check("wr_hit_idle", {busy, req_ready}, 2'b01);

    // Row miss: PRE, ACT after TRP, RD after TRCD
    send(1'b0, 2'd1, 2'd2, 15'h0456, 10'h155, 1'b1);
    check("miss_pre", pins, {5'b01010, 2'd1, 2'd2, 14'h0000});
    des_cycles("miss_trp", 3, 1'b1);
    step();
    check("miss_act", pins, {5'b00000, 2'd1, 2'd2, 14'h0456});
    des_cycles("miss_trcd", 3, 1'b1);
    step();
    check("miss_rd", pins, {5'b01101, 2'd1, 2'd2, 14'h1155});
    check("miss_start", {rd_start, wr_start}, 2'b10);
    des_cycles("miss_burst", 3, 1'b1);
    step();
    check("miss_idle", {busy, req_ready}, 2'b01);

    // Reset during TRCD_WAIT aborts the request and clears the table
    do_reset();
    send(1'b0, 2'd0, 2'd0, 15'h7abc, 10'h003, 1'b0);
    check("abort_act", pins, {5'b00001, 2'd0, 2'd0, 14'h3abc});
    step();
    step();
    reset = 1'b1;
    step();
    check("abort_pins", pins, DES_P);
    check("abort_flags", {busy, req_ready, rd_start, wr_start}, 4'b0100);
    reset = 1'b0;
    des_cycles("abort_quiet", 6, 1'b0);
    send(1'b0, 2'd0, 2'd0, 15'h7abc, 10'h003, 1'b0);
    check("reopen_act", pins, {5'b00001, 2'd0, 2'd0, 14'h3abc});
    des_cycles("reopen_trcd", 3, 1'b1);
    step();
    check("reopen_rd", pins, {5'b01101, 2'd0, 2'd0, 14'h0003});
    des_cycles("reopen_burst", 1, 1'b1);
    step();
    check("reopen_idle", {busy, req_ready}, 2'b01);

`ifdef AUTO_REF_EN
    begin
      int n;
      int ready_hi;
      do_reset();
      send(1'b0, 2'd1, 2'd2, 15'h0123, 10'h040, 1'b1);
      check("ref_open_act", pins, {5'b00000, 2'd1, 2'd2, 14'h0123});
      n = 0;
      step();
      while (pins == DES_P && n < 200) begin
        step();
        n++;
      end
      check("ref_preall", pins, {5'b01010, 2'd0, 2'd0, 14'h0400});
      check("ref_pre_ready", req_ready, 1'b0);
      des_cycles("ref_trp", 3, 1'b1);
      step();
      check("ref_cmd", pins, {5'b01001, 18'h0});
      ready_hi = 0;
      for (int i = 0; i < 19; i++) begin
        step();
        if (req_ready) ready_hi++;
      end
      check("ref_trfc_ready_lo", ready_hi, 0);
      step();
      check("ref_done_ready", {busy, req_ready}, 2'b01);
      send(1'b0, 2'd1, 2'd2, 15'h0123, 10'h040, 1'b1);
      check("ref_after_act", pins, {5'b00000, 2'd1, 2'd2, 14'h0123});
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
